// File: rtl/ras_ctrl_if.sv
// Fetch-side bundle between the fetch pipeline, ras_ctrl and the return address stack.
// master = fetch/stack side, slave = ras_ctrl.
interface ras_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_is_branch;
    logic              fetch_is_call;
    logic              fetch_is_return;
    logic              fetch_compressed;
    logic              fetch_ready;
    logic              retire_branch;
    logic              fetch_flush;
    logic              early_flush;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_new_addr;
    logic              ras_branch_fetched;
    logic              ras_branch_retired;
    logic [ADDR_W-1:0] ras_addr;
    logic [ADDR_W-1:0] ret_target;
    logic              ret_target_valid;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_is_branch,
        output fetch_is_call,
        output fetch_is_return,
        output fetch_compressed,
        input  fetch_ready,
        output retire_branch,
        output fetch_flush,
        output early_flush,
        input  ras_push,
        input  ras_pop,
        input  ras_new_addr,
        input  ras_branch_fetched,
        input  ras_branch_retired,
        output ras_addr,
        input  ret_target,
        input  ret_target_valid
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_is_branch,
        input  fetch_is_call,
        input  fetch_is_return,
        input  fetch_compressed,
        output fetch_ready,
        input  retire_branch,
        input  fetch_flush,
        input  early_flush,
        output ras_push,
        output ras_pop,
        output ras_new_addr,
        output ras_branch_fetched,
        output ras_branch_retired,
        input  ras_addr,
        output ret_target,
        output ret_target_valid
    );
endinterface

// File: rtl/ras_ctrl.sv
// Return address stack fetch-side controller: push/pop decode, link address, in-flight branch count.
// Define RAS_COROUTINE_EN to let call+return in one instruction push and pop together.
module ras_ctrl #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_W          = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    ras_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;

    logic w_flush;
    logic w_run;
    logic w_full;
    logic w_ready;
    logic w_accept;
    logic w_retired;
    logic w_inc;
    logic w_pop_req;
    logic [ADDR_W-1:0] w_step;

    assign w_flush = bus.fetch_flush | bus.early_flush;
    assign w_run   = (r_state == ST_RUN);
    assign w_full  = (r_count == CNT_MAX);

    // A retirement that is dropped by a flush must not free a slot.
    assign w_retired = bus.retire_branch & (r_count != '0) & ~w_flush;

    // A full counter still admits a branch when a slot frees the same cycle.
    assign w_ready  = w_run & ~w_flush
                    & ~(bus.fetch_is_branch & w_full & ~w_retired);
    assign w_accept = bus.fetch_valid & w_ready;
    assign w_inc    = w_accept & bus.fetch_is_branch;

`ifdef RAS_COROUTINE_EN
    assign w_pop_req = bus.fetch_is_return;
`else
    assign w_pop_req = bus.fetch_is_return & ~bus.fetch_is_call;
`endif

    assign w_step = bus.fetch_compressed ? ADDR_W'(2) : ADDR_W'(4);

    assign bus.fetch_ready        = w_ready;
    assign bus.ras_push           = w_accept & bus.fetch_is_call;
    assign bus.ras_pop            = w_accept & w_pop_req;
    assign bus.ras_branch_fetched = w_inc;
    assign bus.ras_branch_retired = w_retired;
    assign bus.ras_new_addr       = bus.fetch_pc + w_step;
    assign bus.ret_target         = bus.ras_addr;
    assign bus.ret_target_valid   = w_run & bus.fetch_valid
                                  & w_pop_req & ~w_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN:  r_state <= w_flush ? ST_HOLD : ST_RUN;
                ST_HOLD: r_state <= w_flush ? ST_HOLD : ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_flush) begin
            r_count <= '0;
        end else begin
            unique case ({w_inc, w_retired})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: expected outputs queued at drive time, popped and checked.
module tb_ras_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ras_ctrl_if #(.ADDR_W(32)) bus ();

    ras_ctrl #(.MAX_OUTSTANDING(8), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic        rdy, push, pop, bf, br, rtv;
        logic [31:0] na, tg;
        int          cnt;
    } exp_t;

    exp_t q[$];

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(
        input string tag, input logic v, input logic [31:0] pc,
        input logic br, input logic c, input logic r, input logic cp,
        input logic rt, input logic ff, input logic ef, input logic [31:0] ra,
        input logic e_rdy, input logic e_push, input logic e_pop,
        input logic e_bf, input logic e_br, input logic e_rtv,
        input logic [31:0] e_na, input logic [31:0] e_tg, input int e_cnt);
        exp_t e;
        @(negedge clk);
        bus.fetch_valid      = v;
        bus.fetch_pc         = pc;
        bus.fetch_is_branch  = br;
        bus.fetch_is_call    = c;
        bus.fetch_is_return  = r;
        bus.fetch_compressed = cp;
        bus.retire_branch    = rt;
        bus.fetch_flush      = ff;
        bus.early_flush      = ef;
        bus.ras_addr         = ra;
        e = '{tag, e_rdy, e_push, e_pop, e_bf, e_br, e_rtv, e_na, e_tg, e_cnt};
        q.push_back(e);
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            cmp({e.tag, ".ready"}, 32'(bus.fetch_ready), 32'(e.rdy));
            cmp({e.tag, ".push"}, 32'(bus.ras_push), 32'(e.push));
            cmp({e.tag, ".pop"}, 32'(bus.ras_pop), 32'(e.pop));
            cmp({e.tag, ".fetched"}, 32'(bus.ras_branch_fetched), 32'(e.bf));
            cmp({e.tag, ".retired"}, 32'(bus.ras_branch_retired), 32'(e.br));
            cmp({e.tag, ".rtv"}, 32'(bus.ret_target_valid), 32'(e.rtv));
            cmp({e.tag, ".new_addr"}, bus.ras_new_addr, e.na);
            cmp({e.tag, ".target"}, bus.ret_target, e.tg);
            @(posedge clk);
            #1;
            cmp({e.tag, ".count"}, 32'(dut.r_count), 32'(e.cnt));
        end
    endtask

    initial begin
        bus.fetch_valid      = 1'b0;
        bus.fetch_pc         = '0;
        bus.fetch_is_branch  = 1'b0;
        bus.fetch_is_call    = 1'b0;
        bus.fetch_is_return  = 1'b0;
        bus.fetch_compressed = 1'b0;
        bus.retire_branch    = 1'b0;
        bus.fetch_flush      = 1'b0;
        bus.early_flush      = 1'b0;
        bus.ras_addr         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //    tag        v  pc            br c  r  cp rt ff ef ras_addr   rdy pu po bf br rtv new_addr      target     cnt
        step("reset",    0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,    1,  0, 0, 0, 0, 0,  32'h4,        32'h0,     0);
        step("call",     1, 32'h1000,     1, 1, 0, 0, 0, 0, 0, 32'h0,    1,  1, 0, 1, 0, 0,  32'h1004,     32'h0,     1);
        step("c_wrap",   1, 32'hFFFFFFFE, 0, 1, 0, 1, 0, 0, 0, 32'h0,    1,  1, 0, 0, 0, 0,  32'h0,        32'h0,     1);
        step("ret",      1, 32'h3000,     0, 0, 1, 0, 0, 0, 0, 32'h2008, 1,  0, 1, 0, 0, 1,  32'h3004,     32'h2008,  1);
        step("ret_idle", 0, 32'h3000,     0, 0, 1, 0, 0, 0, 0, 32'h2008, 1,  0, 0, 0, 0, 0,  32'h3004,     32'h2008,  1);
        for (int i = 0; i < 7; i++)
            step("fill",  1, 32'h100 + 32'(i*4), 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 0, 32'h104 + 32'(i*4), 32'h0, i + 2);
        step("full",     1, 32'h200,      1, 0, 0, 0, 0, 0, 0, 32'h0,    0,  0, 0, 0, 0, 0,  32'h204,      32'h0,     8);
        step("full_nb",  1, 32'h300,      0, 1, 0, 0, 0, 0, 0, 32'h0,    1,  1, 0, 0, 0, 0,  32'h304,      32'h0,     8);
        step("full_rt",  1, 32'h200,      1, 0, 0, 0, 1, 0, 0, 32'h0,    1,  0, 0, 1, 1, 0,  32'h204,      32'h0,     8);
        for (int i = 0; i < 5; i++)
            step("drain", 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 32'h4, 32'h0, 7 - i);
        step("flush",    1, 32'h400,      1, 1, 0, 0, 1, 1, 0, 32'h0,    0,  0, 0, 0, 0, 0,  32'h404,      32'h0,     0);
        step("hold",     1, 32'h400,      1, 1, 0, 0, 0, 0, 0, 32'h0,    0,  0, 0, 0, 0, 0,  32'h404,      32'h0,     0);
        step("rt_zero",  0, 32'h0,        0, 0, 0, 0, 1, 0, 0, 32'h0,    1,  0, 0, 0, 0, 0,  32'h4,        32'h0,     0);
        step("eflush",   1, 32'h500,      0, 0, 1, 1, 0, 0, 1, 32'h77,   0,  0, 0, 0, 0, 0,  32'h502,      32'h77,    0);
        step("eflush2",  1, 32'h500,      0, 0, 1, 1, 0, 0, 1, 32'h77,   0,  0, 0, 0, 0, 0,  32'h502,      32'h77,    0);
        step("hold2",    1, 32'h500,      0, 0, 1, 1, 0, 0, 0, 32'h77,   0,  0, 0, 0, 0, 0,  32'h502,      32'h77,    0);
        step("run2",     1, 32'h500,      0, 0, 1, 1, 0, 0, 0, 32'h77,   1,  0, 1, 0, 0, 1,  32'h502,      32'h77,    0);
`ifdef RAS_COROUTINE_EN
        step("corout",   1, 32'h600,      0, 1, 1, 0, 0, 0, 0, 32'h5550, 1,  1, 1, 0, 0, 1,  32'h604,      32'h5550,  0);
`else
        step("corout",   1, 32'h600,      0, 1, 1, 0, 0, 0, 0, 32'h5550, 1,  1, 0, 0, 0, 0,  32'h604,      32'h5550,  0);
`endif
        cmp("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
